// File: rtl/ghost_hit_monitor_if.sv
// Signal bundle between the game top level and ghost_hit_monitor:
// per-frame sprite positions in, damage/lives status out.
interface ghost_hit_monitor_if;
   logic       frame_tick;
   logic [9:0] y_x;
   logic [9:0] y_y;
   logic [9:0] g0_x;
   logic [9:0] g0_y;
   logic [9:0] g1_x;
   logic [9:0] g1_y;
   logic [9:0] g2_x;
   logic [9:0] g2_y;
   logic [2:0] ghost_en;
   logic       restart;
   logic [2:0] lives;
   logic       hit;
   logic [1:0] hit_id;
   logic       invincible;
   logic       flash;
   logic       game_over;

   modport master (
      output frame_tick, y_x, y_y, g0_x, g0_y, g1_x, g1_y, g2_x, g2_y, ghost_en, restart,
      input  lives, hit, hit_id, invincible, flash, game_over
   );

   modport slave (
      input  frame_tick, y_x, y_y, g0_x, g0_y, g1_x, g1_y, g2_x, g2_y, ghost_en, restart,
      output lives, hit, hit_id, invincible, flash, game_over
   );
endinterface

// File: rtl/ghost_hit_monitor.sv
// Yoshi/ghost contact detector and damage state machine.
// Once per frame the positions are snapshotted, the three ghosts are compared
// sequentially against Yoshi with a shrunken hitbox, and the damage FSM
// updates lives, invincibility, blink and game-over.
module ghost_hit_monitor #(
   parameter int SPR_W      = 16,
   parameter int HIT_MARGIN = 2,
   parameter int LIVES_INIT = 3,
   parameter int INV_FRAMES = 120
) (
   input  logic               clk,
   input  logic               reset_n,
   ghost_hit_monitor_if.slave bus
);

   localparam logic [10:0] LIM       = 11'(SPR_W - 2 * HIT_MARGIN);
   localparam logic [2:0]  LIVES_RST = 3'(LIVES_INIT);
   localparam logic [7:0]  INV_LOAD  = 8'(INV_FRAMES);

   typedef enum logic [2:0] {SC_IDLE, SC_CMP0, SC_CMP1, SC_CMP2, SC_DONE} sc_t;
   typedef enum logic [1:0] {PLAY, HIT, GAME_OVER} dm_t;

   sc_t        sc_state, sc_nx;
   dm_t        dm_state, dm_nx;
   logic [9:0] s_y_x, s_y_y, s_g0_x, s_g0_y, s_g1_x, s_g1_y, s_g2_x, s_g2_y;
   logic [2:0] s_en;
   logic       snap_en;
   logic       hit_any, hit_any_nx;
   logic [1:0] first_id, first_nx;
   logic       armed, armed_nx;
   logic [2:0] lives_q, lives_nx;
   logic [7:0] inv_q, inv_nx;
   logic       hit_q, hit_nx;
   logic [1:0] hit_id_q, hit_id_nx;
   logic [9:0] cx, cy;
   logic       cen;
   logic [1:0] cid;
   logic [10:0] dx, dy, adx, ady;
   logic       contact;

   // Select the ghost under comparison and evaluate the 11-bit overlap test
   always_comb begin
      cx  = s_g0_x;
      cy  = s_g0_y;
      cen = s_en[0];
      cid = 2'd0;
      case (sc_state)
         SC_CMP1: begin
            cx  = s_g1_x;
            cy  = s_g1_y;
            cen = s_en[1];
            cid = 2'd1;
         end
         SC_CMP2: begin
            cx  = s_g2_x;
            cy  = s_g2_y;
            cen = s_en[2];
            cid = 2'd2;
         end
         default: ;
      endcase
      dx      = {1'b0, cx} - {1'b0, s_y_x};
      dy      = {1'b0, cy} - {1'b0, s_y_y};
      adx     = dx[10] ? (~dx + 11'd1) : dx;
      ady     = dy[10] ? (~dy + 11'd1) : dy;
      contact = cen && (adx < LIM) && (ady < LIM);
   end

   // Next-state logic for scanner and damage FSMs
   always_comb begin
      sc_nx      = sc_state;
      dm_nx      = dm_state;
      snap_en    = 1'b0;
      hit_any_nx = hit_any;
      first_nx   = first_id;
      armed_nx   = armed;
      lives_nx   = lives_q;
      inv_nx     = inv_q;
      hit_nx     = 1'b0;
      hit_id_nx  = hit_id_q;

      case (sc_state)
         SC_IDLE: begin
            if (bus.frame_tick) begin
               sc_nx      = SC_CMP0;
               snap_en    = 1'b1;
               hit_any_nx = 1'b0;
               first_nx   = 2'd0;
               // A scan started outside PLAY never causes damage, even if the
               // invincibility window ends on this same tick.
               armed_nx   = (dm_state == PLAY);
            end
         end
         SC_CMP0: sc_nx = SC_CMP1;
         SC_CMP1: sc_nx = SC_CMP2;
         SC_CMP2: sc_nx = SC_DONE;
         SC_DONE: sc_nx = SC_IDLE;
         default: sc_nx = SC_IDLE;
      endcase

      if ((sc_state == SC_CMP0 || sc_state == SC_CMP1 || sc_state == SC_CMP2)
          && contact && !hit_any) begin
         hit_any_nx = 1'b1;
         first_nx   = cid;
      end

      case (dm_state)
         PLAY: begin
            if (sc_state == SC_DONE && armed && hit_any) begin
               hit_nx    = 1'b1;
               hit_id_nx = first_id;
               if (lives_q > 3'd1) begin
                  lives_nx = lives_q - 3'd1;
                  inv_nx   = INV_LOAD;
                  dm_nx    = HIT;
               end else begin
                  lives_nx = '0;
                  dm_nx    = GAME_OVER;
               end
            end
         end
         HIT: begin
            if (sc_state == SC_IDLE && bus.frame_tick) begin
               inv_nx = inv_q - 8'd1;
               if (inv_q == 8'd1) dm_nx = PLAY;
            end
         end
         GAME_OVER: begin
            if (bus.restart) begin
               lives_nx  = LIVES_RST;
               hit_id_nx = '0;
               dm_nx     = PLAY;
               sc_nx     = SC_IDLE;
               snap_en   = 1'b0;
            end
         end
         default: dm_nx = PLAY;
      endcase
   end

   // State, snapshot and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sc_state <= SC_IDLE;
         dm_state <= PLAY;
         s_y_x    <= '0;
         s_y_y    <= '0;
         s_g0_x   <= '0;
         s_g0_y   <= '0;
         s_g1_x   <= '0;
         s_g1_y   <= '0;
         s_g2_x   <= '0;
         s_g2_y   <= '0;
         s_en     <= '0;
         hit_any  <= 1'b0;
         first_id <= '0;
         armed    <= 1'b0;
         lives_q  <= LIVES_RST;
         inv_q    <= '0;
         hit_q    <= 1'b0;
         hit_id_q <= '0;
      end else begin
         sc_state <= sc_nx;
         dm_state <= dm_nx;
         if (snap_en) begin
            s_y_x  <= bus.y_x;
            s_y_y  <= bus.y_y;
            s_g0_x <= bus.g0_x;
            s_g0_y <= bus.g0_y;
            s_g1_x <= bus.g1_x;
            s_g1_y <= bus.g1_y;
            s_g2_x <= bus.g2_x;
            s_g2_y <= bus.g2_y;
            s_en   <= bus.ghost_en;
         end
         hit_any  <= hit_any_nx;
         first_id <= first_nx;
         armed    <= armed_nx;
         lives_q  <= lives_nx;
         inv_q    <= inv_nx;
         hit_q    <= hit_nx;
         hit_id_q <= hit_id_nx;
      end
   end

   assign bus.lives      = lives_q;
   assign bus.hit        = hit_q;
   assign bus.hit_id     = hit_id_q;
   assign bus.invincible = (dm_state == HIT);
   assign bus.flash      = (dm_state == HIT) & inv_q[3];
   assign bus.game_over  = (dm_state == GAME_OVER);

endmodule
